// File: rtl/exc_pkg.sv
// Shared types and constants for the exception sequencer: state encoding,
// cause codes and default handler-vector addresses.
package exc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAVE_EPC,
        MEM_ADDR,
        MEM_WAIT,
        LOAD_PC,
        DONE
    } exc_state_t;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_OVF  = 2'b01;
    localparam logic [1:0] CAUSE_OPC  = 2'b10;

    localparam logic [31:0] DEF_OVF_VECTOR_ADDR = 32'd255;
    localparam logic [31:0] DEF_OPC_VECTOR_ADDR = 32'd254;

    // Overflow has its own vector; every other latched cause uses the opcode vector.
    function automatic logic [31:0] vector_addr(input logic [1:0]  cause,
                                                input logic [31:0] ovf_addr,
                                                input logic [31:0] opc_addr);
        return (cause == CAUSE_OVF) ? ovf_addr : opc_addr;
    endfunction

endpackage

// File: rtl/exc_wait_counter.sv
// Loadable down-counter that times the memory read latency; terminal flags
// the last wait cycle (count == 1).
module exc_wait_counter #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             terminal
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign terminal = (count == WIDTH'(1));

endmodule

// File: rtl/exception_sequencer.sv
// Multicycle exception takeover: saves EPC, fetches the handler vector byte
// from a fixed address and loads it into PC, then releases the datapath.
module exception_sequencer
    import exc_pkg::*;
#(
    parameter int unsigned MEM_READ_WAIT   = 1,
    parameter logic [31:0] OVF_VECTOR_ADDR = DEF_OVF_VECTOR_ADDR,
    parameter logic [31:0] OPC_VECTOR_ADDR = DEF_OPC_VECTOR_ADDR
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        ovf_req,
    input  logic        opc_req,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_data,
    output logic        busy,
    output logic        done,
    output logic [1:0]  cause,
    output logic        epc_load,
    output logic [31:0] epc_value,
    output logic        mem_sel,
    output logic [31:0] mem_addr,
    output logic        pc_load,
    output logic [31:0] pc_value
);

    localparam int unsigned CNT_W_RAW = $clog2(MEM_READ_WAIT + 1);
    localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;

    exc_state_t  state;
    exc_state_t  next_state;
    logic [1:0]  cause_r;
    logic [31:0] pc_r;
    logic        wait_last;
    logic        accept;
    logic        unused_mem_bits;

    // Only the low byte of the vector word is meaningful.
    assign unused_mem_bits = ^mem_data[31:8];

    assign accept = (state == IDLE) && (ovf_req || opc_req);

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state   <= IDLE;
            cause_r <= CAUSE_NONE;
            pc_r    <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                cause_r <= opc_req ? CAUSE_OPC : CAUSE_OVF;
                pc_r    <= pc_in;
            end
        end
    end

    exc_wait_counter #(
        .WIDTH (CNT_W)
    ) u_wait_counter (
        .clk        (Clk),
        .reset      (reset),
        .load       (state == MEM_ADDR),
        .load_value (CNT_W'(MEM_READ_WAIT)),
        .dec        (state == MEM_WAIT),
        .terminal   (wait_last)
    );

    always_comb begin
        next_state = state;
        done       = 1'b0;
        epc_load   = 1'b0;
        epc_value  = '0;
        mem_sel    = 1'b0;
        mem_addr   = '0;
        pc_load    = 1'b0;
        pc_value   = '0;
        case (state)
            IDLE: begin
                if (ovf_req || opc_req) next_state = SAVE_EPC;
            end
            SAVE_EPC: begin
                epc_load   = 1'b1;
                epc_value  = pc_r - 32'd4;
                next_state = MEM_ADDR;
            end
            MEM_ADDR: begin
                mem_sel    = 1'b1;
                mem_addr   = vector_addr(cause_r, OVF_VECTOR_ADDR, OPC_VECTOR_ADDR);
                next_state = (MEM_READ_WAIT == 0) ? LOAD_PC : MEM_WAIT;
            end
            MEM_WAIT: begin
                mem_sel  = 1'b1;
                mem_addr = vector_addr(cause_r, OVF_VECTOR_ADDR, OPC_VECTOR_ADDR);
                if (wait_last) next_state = LOAD_PC;
            end
            LOAD_PC: begin
                mem_sel    = 1'b1;
                mem_addr   = vector_addr(cause_r, OVF_VECTOR_ADDR, OPC_VECTOR_ADDR);
                pc_load    = 1'b1;
                pc_value   = {24'd0, mem_data[7:0]};
                next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy  = (state != IDLE);
    assign cause = cause_r;

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench: three sequencer instances (read wait 0, 1, 3) share inputs
// and are checked cycle by cycle against hand-computed values.
module tb_exception_sequencer;

    localparam int W0 = 0;
    localparam int W1 = 1;
    localparam int W3 = 2;

    logic        Clk = 1'b0;
    logic        reset;
    logic        ovf_req;
    logic        opc_req;
    logic [31:0] pc_in;
    logic [31:0] mem_data;

    logic [2:0]  busy;
    logic [2:0]  done;
    logic [1:0]  cause     [3];
    logic [2:0]  epc_load;
    logic [31:0] epc_value [3];
    logic [2:0]  mem_sel;
    logic [31:0] mem_addr  [3];
    logic [2:0]  pc_load;
    logic [31:0] pc_value  [3];

    int errors = 0;
    int checks = 0;
    int done_count;
    int done_at;

    always #5 Clk = ~Clk;

    exception_sequencer #(.MEM_READ_WAIT(0)) dut_w0 (
        .Clk(Clk), .reset(reset), .ovf_req(ovf_req), .opc_req(opc_req),
        .pc_in(pc_in), .mem_data(mem_data), .busy(busy[W0]), .done(done[W0]),
        .cause(cause[W0]), .epc_load(epc_load[W0]), .epc_value(epc_value[W0]),
        .mem_sel(mem_sel[W0]), .mem_addr(mem_addr[W0]), .pc_load(pc_load[W0]),
        .pc_value(pc_value[W0])
    );

    exception_sequencer #(.MEM_READ_WAIT(1)) dut_w1 (
        .Clk(Clk), .reset(reset), .ovf_req(ovf_req), .opc_req(opc_req),
        .pc_in(pc_in), .mem_data(mem_data), .busy(busy[W1]), .done(done[W1]),
        .cause(cause[W1]), .epc_load(epc_load[W1]), .epc_value(epc_value[W1]),
        .mem_sel(mem_sel[W1]), .mem_addr(mem_addr[W1]), .pc_load(pc_load[W1]),
        .pc_value(pc_value[W1])
    );

    exception_sequencer #(.MEM_READ_WAIT(3)) dut_w3 (
        .Clk(Clk), .reset(reset), .ovf_req(ovf_req), .opc_req(opc_req),
        .pc_in(pc_in), .mem_data(mem_data), .busy(busy[W3]), .done(done[W3]),
        .cause(cause[W3]), .epc_load(epc_load[W3]), .epc_value(epc_value[W3]),
        .mem_sel(mem_sel[W3]), .mem_addr(mem_addr[W3]), .pc_load(pc_load[W3]),
        .pc_value(pc_value[W3])
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Hold a request for exactly one edge; afterwards the bench sits in cycle 1.
    task automatic request(input logic ovf, input logic opc, input logic [31:0] pc);
        ovf_req = ovf;
        opc_req = opc;
        pc_in   = pc;
        step();
        ovf_req = 1'b0;
        opc_req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag, input int d);
        check({tag, "_busy"},      32'(busy[d]),     32'd0);
        check({tag, "_done"},      32'(done[d]),     32'd0);
        check({tag, "_cause"},     32'(cause[d]),    32'd0);
        check({tag, "_epc_load"},  32'(epc_load[d]), 32'd0);
        check({tag, "_epc_value"}, epc_value[d],     32'd0);
        check({tag, "_mem_sel"},   32'(mem_sel[d]),  32'd0);
        check({tag, "_mem_addr"},  mem_addr[d],      32'd0);
        check({tag, "_pc_load"},   32'(pc_load[d]),  32'd0);
        check({tag, "_pc_value"},  pc_value[d],      32'd0);
    endtask

    initial begin
        reset    = 1'b0;
        ovf_req  = 1'b0;
        opc_req  = 1'b0;
        pc_in    = '0;
        mem_data = '0;
        repeat (3) step();
        check_all_zero("rst_w1", W1);
        check("rst_w3_busy", 32'(busy[W3]), 32'd0);
        reset = 1'b1;
        step();
        check("idle_busy", 32'(busy[W1]), 32'd0);

        // Overflow at default wait
        mem_data = 32'h0000_0A80;
        request(1'b1, 1'b0, 32'h0000_0040);
        check("ovf_c1_epc_load",  32'(epc_load[W1]), 32'd1);
        check("ovf_c1_epc_value", epc_value[W1],     32'h3C);
        check("ovf_c1_busy",      32'(busy[W1]),     32'd1);
        check("ovf_c1_mem_sel",   32'(mem_sel[W1]),  32'd0);
        check("ovf_c1_cause",     32'(cause[W1]),    32'd1);
        step();
        check("ovf_c2_mem_sel",   32'(mem_sel[W1]),  32'd1);
        check("ovf_c2_mem_addr",  mem_addr[W1],      32'd255);
        check("ovf_c2_epc_load",  32'(epc_load[W1]), 32'd0);
        check("ovf_c2_epc_value", epc_value[W1],     32'd0);
        step();
        check("ovf_c3_mem_sel",   32'(mem_sel[W1]),  32'd1);
        check("ovf_c3_mem_addr",  mem_addr[W1],      32'd255);
        check("ovf_c3_pc_load",   32'(pc_load[W1]),  32'd0);
        step();
        check("ovf_c4_pc_load",   32'(pc_load[W1]),  32'd1);
        check("ovf_c4_pc_value",  pc_value[W1],      32'h80);
        check("ovf_c4_mem_addr",  mem_addr[W1],      32'd255);
        check("ovf_c4_done",      32'(done[W1]),     32'd0);
        step();
        check("ovf_c5_done",      32'(done[W1]),     32'd1);
        check("ovf_c5_pc_load",   32'(pc_load[W1]),  32'd0);
        check("ovf_c5_pc_value",  pc_value[W1],      32'd0);
        check("ovf_c5_busy",      32'(busy[W1]),     32'd1);
        step();
        check("ovf_c6_done",      32'(done[W1]),     32'd0);
        check("ovf_c6_busy",      32'(busy[W1]),     32'd0);
        check("ovf_c6_cause",     32'(cause[W1]),    32'd1);
        repeat (4) step();

        // Simultaneous requests: opcode wins
        request(1'b1, 1'b1, 32'd8);
        check("sim_cause",     32'(cause[W1]), 32'd2);
        check("sim_epc_value", epc_value[W1],  32'd4);
        step();
        check("sim_mem_addr",    mem_addr[W1], 32'd254);
        check("sim_w3_mem_addr", mem_addr[W3], 32'd254);
        repeat (8) step();

        // EPC wraps below zero
        request(1'b0, 1'b1, 32'd0);
        check("wrap_epc_value", epc_value[W1],  32'hFFFF_FFFC);
        check("wrap_cause",     32'(cause[W1]), 32'd2);
        repeat (8) step();

        // Requests while busy are dropped
        mem_data = 32'h0000_0A80;
        request(1'b1, 1'b0, 32'h0000_0040);
        done_count = 0;
        done_at    = 0;
        for (int i = 1; i <= 12; i++) begin
            ovf_req = (i == 2 || i == 3);
            if (done[W1]) begin
                done_count++;
                done_at = i;
            end
            step();
        end
        ovf_req = 1'b0;
        check("busyreq_done_count", 32'(done_count), 32'd1);
        check("busyreq_done_at",    32'(done_at),    32'd5);
        check("busyreq_idle",       32'(busy[W1]),   32'd0);
        check("busyreq_w3_idle",    32'(busy[W3]),   32'd0);

        // Read wait 0 and 3 timing, run together
        mem_data = 32'h1234_5633;
        request(1'b1, 1'b0, 32'h0000_0100);
        for (int i = 1; i <= 9; i++) begin
            check($sformatf("w0_c%0d_pc_load", i), 32'(pc_load[W0]), 32'(i == 3));
            check($sformatf("w0_c%0d_done", i),    32'(done[W0]),    32'(i == 4));
            check($sformatf("w0_c%0d_busy", i),    32'(busy[W0]),    32'(i <= 4));
            check($sformatf("w3_c%0d_pc_load", i), 32'(pc_load[W3]), 32'(i == 6));
            check($sformatf("w3_c%0d_done", i),    32'(done[W3]),    32'(i == 7));
            check($sformatf("w3_c%0d_mem_addr", i), mem_addr[W3],
                  (i >= 2 && i <= 6) ? 32'd255 : 32'd0);
            if (i == 6) check("w3_pc_value", pc_value[W3], 32'h33);
            if (i == 3) check("w0_pc_value", pc_value[W0], 32'h33);
            step();
        end

        // Reset in the middle of the wait state
        request(1'b1, 1'b0, 32'h0000_0200);
        step();
        step();
        check("mid_pre_mem_sel", 32'(mem_sel[W1]), 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check_all_zero("mid_rst_w1", W1);
        check_all_zero("mid_rst_w3", W3);
        for (int i = 0; i < 4; i++) begin
            step();
            check("mid_no_done", 32'(done[W1] | done[W3]), 32'd0);
            check("mid_idle",    32'(busy[W1]),            32'd0);
        end
        mem_data = 32'h0000_0A80;
        request(1'b1, 1'b0, 32'h0000_0044);
        check("post_epc_value", epc_value[W1], 32'h40);
        done_count = 0;
        done_at    = 0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 4) check("post_pc_value", pc_value[W1], 32'h80);
            if (done[W1]) begin
                done_count++;
                done_at = i;
            end
            step();
        end
        check("post_done_count", 32'(done_count), 32'd1);
        check("post_done_at",    32'(done_at),    32'd5);
        check("post_cause",      32'(cause[W1]),  32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
